seq_dbg_cmd_arbiter: RTL

- Shares the sequencer core-debug command mailbox between NUM_REQ requesters, e.g. JTAG debug bridge and on-chip margining logic.
- Runs on the sequencer Avalon-MM debug port. Mailbox base is CMD_BASE = debug base 0x153B4 + 0x8. REQ_CMD is at +0x0, CMD_STATUS at +0x4, CMD_PARAMS at +0x8.
- Per granted request: write the parameter words, write the command code, poll status until completion or timeout, clear status, return the result to the winner.

---
 rtl/seq_dbg_cmd_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_dbg_cmd_arbiter.sv
// Round-robin arbiter that shares the sequencer debug command mailbox between
// NUM_REQ requesters and runs each granted command over Avalon-MM.
module seq_dbg_cmd_arbiter #(
  parameter int          NUM_REQ    = 2,
  parameter int          NUM_PARAMS = 4,
  parameter int          ADDR_WIDTH = 20,
  parameter logic [31:0] CMD_BASE   = 32'h000153BC,
  parameter int          POLL_GAP   = 16,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                             avl_clk,
  input  logic                             avl_reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*32-1:0]            req_cmd,
  input  logic [NUM_REQ*NUM_PARAMS*32-1:0] req_params,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [31:0]                      rsp_status,
  output logic                             rsp_timeout,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            avm_address,
  output logic                             avm_read,
  output logic                             avm_write,
  output logic [31:0]                      avm_writedata,
  input  logic [31:0]                      avm_readdata,
  input  logic                             avm_waitrequest
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PAR_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PARAM, S_WR_CMD, S_GAP, S_POLL, S_ABORT, S_ACK, S_RESP
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] mbox_addr(input logic [31:0] off);
    return ADDR_WIDTH'(CMD_BASE + off);
  endfunction

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d, win_q, win_d;
  logic [31:0]                  cmd_q, cmd_d;
  logic [NUM_PARAMS*32-1:0]     params_q, params_d;
  logic [PAR_W-1:0]             pidx_q, pidx_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [CNT_W-1:0]             poll_q, poll_d, poll_inc;
  logic [31:0]                  result_q, result_d;
  logic                         tmo_q, tmo_d;

  logic [NUM_REQ-1:0]           grant_q, grant_d, rspv_q, rspv_d;
  logic [31:0]                  rsps_q, rsps_d, wdata_q, wdata_d;
  logic                         rspt_q, rspt_d, busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic                         rd_q, rd_d, wr_q, wr_d;

  logic                         xfer_done, found;
  logic [PTR_W-1:0]             pick;
  int                           idx;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cmd_d    = cmd_q;
    params_d = params_q;
    pidx_d   = pidx_q;
    gap_d    = gap_q;
    poll_d   = poll_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    grant_d  = '0;
    xfer_done = (rd_q | wr_q) & ~avm_waitrequest;
    poll_inc  = (poll_q == CNT_W'(POLL_LIMIT)) ? poll_q : poll_q + 1'b1;

    // Round-robin search starting at the pointer, wrapping upward.
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end

    case (state_q)
      S_IDLE: if (found) begin
        win_d          = pick;
        cmd_d          = req_cmd[int'(pick)*32 +: 32];
        params_d       = req_params[int'(pick)*NUM_PARAMS*32 +: NUM_PARAMS*32];
        grant_d[pick]  = 1'b1;
        ptr_d          = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
        pidx_d         = '0;
        state_d        = S_WR_PARAM;
      end
      S_WR_PARAM: if (xfer_done) begin
        if (pidx_q == PAR_W'(NUM_PARAMS - 1)) state_d = S_WR_CMD;
        else                                  pidx_d  = pidx_q + 1'b1;
      end
      S_WR_CMD: if (xfer_done) begin
        poll_d  = '0;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_POLL: if (xfer_done) begin
        poll_d = poll_inc;
        if (avm_readdata != 32'h0) begin
          result_d = avm_readdata;
          tmo_d    = 1'b0;
          state_d  = S_ACK;
        end else if (poll_inc == CNT_W'(POLL_LIMIT)) begin
          result_d = 32'hFFFF_FFFF;
          tmo_d    = 1'b1;
          state_d  = S_ABORT;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_ABORT: if (xfer_done) state_d = S_ACK;
      S_ACK:   if (xfer_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    rspv_d = '0;
    rsps_d = '0;
    rspt_d = 1'b0;
    if (state_d == S_RESP) begin
      rspv_d[win_d] = 1'b1;
      rsps_d        = result_d;
      rspt_d        = tmo_d;
    end

    // Bus strobes follow the next state, so a stalled transfer re-derives identical
    // values; the grant cycle itself stays quiet on the bus.
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (grant_d == '0) begin
      case (state_d)
        S_WR_PARAM: begin
          wr_d    = 1'b1;
          addr_d  = mbox_addr(32'd8 + (32'(pidx_d) << 2));
          wdata_d = params_d[int'(pidx_d)*32 +: 32];
        end
        S_WR_CMD: begin
          wr_d    = 1'b1;
          addr_d  = mbox_addr(32'd0);
          wdata_d = cmd_d;
        end
        S_POLL: begin
          rd_d   = 1'b1;
          addr_d = mbox_addr(32'd4);
        end
        S_ABORT: begin
          wr_d   = 1'b1;
          addr_d = mbox_addr(32'd0);
        end
        S_ACK: begin
          wr_d   = 1'b1;
          addr_d = mbox_addr(32'd4);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      pidx_q  <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      grant_q <= '0;
      rspv_q  <= '0;
      rsps_q  <= '0;
      rspt_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pidx_q  <= pidx_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      grant_q <= grant_d;
      rspv_q  <= rspv_d;
      rsps_q  <= rsps_d;
      rspt_q  <= rspt_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Latched command payload and result only matter once a grant has loaded them.
  always_ff @(posedge avl_clk) begin
    win_q    <= win_d;
    cmd_q    <= cmd_d;
    params_q <= params_d;
    result_q <= result_d;
    tmo_q    <= tmo_d;
  end

  assign req_grant     = grant_q;
  assign rsp_valid     = rspv_q;
  assign rsp_status    = rsps_q;
  assign rsp_timeout   = rspt_q;
  assign busy          = busy_q;
  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;

endmodule
